// File: rtl/alu_issue.sv
// alu_issue: issue/writeback front end for the 16-bit arithmetic datapath.
//
// Decodes arithmetic-class instructions, reads the 8x16 register file and
// registers operands/opcode into the issue slot that feeds an external
// combinational ALU. One edge later the ALU result and its SZCV flags are
// committed, together with the IN/OUT/HLT side effects. The value being
// committed is forwarded to the instruction issuing on the same edge, so
// dependent instructions issue back to back without stalling.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   instr_valid/ready   instruction handshake (accept = valid && ready)
//   instr               [15:14]=11 class, [13:11] Rs, [10:8] Rd, [7:4] op3, [3:0] d
//   alu_AR/BR/d/opselect/isValid   registered issue slot driving the ALU
//   alu_out, alu_S/Z/C/V           ALU result and flags
//   alu_*Flag                      ALU commit controls
//   in_data             external value written by IN
//   out_data/out_valid  last OUT value and its one-cycle update pulse
//   szcv                flag register {S,Z,C,V}
//   halted              sticky halt, cleared only by reset
//   illegal             one-cycle pulse for an accepted undecodable instruction
module alu_issue #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [WIDTH-1:0] alu_AR,
  output logic [WIDTH-1:0] alu_BR,
  output logic [3:0]       alu_d,
  output logic [3:0]       alu_opselect,
  output logic             alu_isValid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_S,
  input  logic             alu_Z,
  input  logic             alu_C,
  input  logic             alu_V,
  input  logic             alu_iRdWriteFlag,
  input  logic             alu_SZCVWriteFlag,
  input  logic             alu_inputFlag,
  input  logic             alu_outputFlag,
  input  logic             alu_HaltFlag,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [3:0]       szcv,
  output logic             halted,
  output logic             illegal
);

  localparam logic [3:0] OpMov  = 4'b0110;
  localparam logic [3:0] OpHlt  = 4'b1111;
  localparam logic [3:0] OpBad0 = 4'b0111;
  localparam logic [3:0] OpBad1 = 4'b1110;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] ar_q, ar_d, br_q, br_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [3:0]       d_q, d_d, op_q, op_d, szcv_q, szcv_d;
  logic [2:0]       rd_q, rd_d;
  logic             valid_q, valid_d;
  logic             outValid_q, outValid_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;

  logic [2:0]       rsField, rdField;
  logic [3:0]       opField, dField;
  logic             isLegal, accept, fwdEn;
  logic [WIDTH-1:0] writeVal, rsVal, rdVal;

  assign rsField = instr[13:11];
  assign rdField = instr[10:8];
  assign opField = instr[7:4];
  assign dField  = instr[3:0];

  assign isLegal = (instr[15:14] == 2'b11) && (opField != OpBad0) && (opField != OpBad1);

  // A HLT sitting in the issue slot blocks new work so nothing issues behind it.
  assign instr_ready = !halted_q && !(valid_q && (op_q == OpHlt));
  assign accept      = instr_valid && instr_ready;

  // Value being committed this cycle, also the forwarding source.
  assign writeVal = alu_inputFlag ? in_data : alu_out;
  assign fwdEn    = valid_q && alu_iRdWriteFlag;
  assign rsVal    = (fwdEn && (rsField == rd_q)) ? writeVal : regs_q[rsField];
  assign rdVal    = (fwdEn && (rdField == rd_q)) ? writeVal : regs_q[rdField];

  // Next-state logic: commit of the occupied issue slot, then issue of the
  // newly accepted instruction. Operand registers hold across bubbles and
  // illegal instructions; only the valid bit drops.
  always_comb begin
    regs_d     = regs_q;
    ar_d       = ar_q;
    br_d       = br_q;
    d_d        = d_q;
    op_d       = op_q;
    rd_d       = rd_q;
    szcv_d     = szcv_q;
    outData_d  = outData_q;
    halted_d   = halted_q;
    valid_d    = 1'b0;
    outValid_d = 1'b0;
    illegal_d  = 1'b0;

    if (valid_q) begin
      if (alu_iRdWriteFlag) begin
        regs_d[rd_q] = writeVal;
      end
      if (alu_SZCVWriteFlag) begin
        szcv_d = {alu_S, alu_Z, alu_C, alu_V};
      end
      if (alu_outputFlag) begin
        outData_d  = ar_q;
        outValid_d = 1'b1;
      end
      if (alu_HaltFlag) begin
        halted_d = 1'b1;
      end
    end

    if (accept) begin
      if (isLegal) begin
        valid_d = 1'b1;
        op_d    = opField;
        d_d     = dField;
        rd_d    = rdField;
        ar_d    = rsVal;
        br_d    = (opField == OpMov) ? rsVal : rdVal;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any in-flight issue so nothing commits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      ar_q       <= '0;
      br_q       <= '0;
      d_q        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      szcv_q     <= '0;
      outData_q  <= '0;
      halted_q   <= 1'b0;
      valid_q    <= 1'b0;
      outValid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      ar_q       <= ar_d;
      br_q       <= br_d;
      d_q        <= d_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      szcv_q     <= szcv_d;
      outData_q  <= outData_d;
      halted_q   <= halted_d;
      valid_q    <= valid_d;
      outValid_q <= outValid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_AR       = ar_q;
  assign alu_BR       = br_q;
  assign alu_d        = d_q;
  assign alu_opselect = op_q;
  assign alu_isValid  = valid_q;
  assign out_data     = outData_q;
  assign out_valid    = outValid_q;
  assign szcv         = szcv_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;

endmodule
